// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: sweeps every input combination of a small
// combinational unit, waits SETTLE cycles per combination, samples the
// unit's single output and compares the captured truth table to EXPECTED.
//
// state  | meaning
// IDLE   | waiting for start; tt holds the last result
// WAIT   | stim applied, counting settle cycles
// SAMPLE | capture f_in into tt[stim], advance or finish
// DONE   | result valid on tt/pass until ack
module truth_table_sequencer #(
  parameter int N_INPUTS = 2,
  parameter int SETTLE   = 2,
  parameter logic [2**N_INPUTS-1:0] EXPECTED = {(2**N_INPUTS){1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   ack,
  input  logic                   f_in,
  output logic [N_INPUTS-1:0]    stim,
  output logic                   busy,
  output logic                   done,
  output logic [2**N_INPUTS-1:0] tt,
  output logic                   pass
);

  localparam int N_COMB = 2**N_INPUTS;
  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [N_INPUTS-1:0] STIM_LAST = {N_INPUTS{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [N_INPUTS-1:0] r_stim;
  logic [N_COMB-1:0]   r_tt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [N_COMB-1:0]   w_tt_next;

  // Truth table as it will look once the current sample is written; used
  // so pass can be registered on the same edge that enters DONE.
  always_comb begin
    w_tt_next         = r_tt;
    w_tt_next[r_stim] = f_in;
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stim  <= '0;
      r_tt    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= WAIT;
            r_tt    <= '0;
            r_stim  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= SAMPLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          r_tt  <= w_tt_next;
          r_cnt <= '0;
          if (r_stim == STIM_LAST) begin
            // stim deliberately holds at all-ones: no wrap-around.
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_tt_next == EXPECTED);
          end else begin
            r_stim  <= r_stim + 1'b1;
            r_state <= WAIT;
          end
        end
        DONE: begin
          // ack takes priority; a simultaneous start is dropped.
          if (ack) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign stim = r_stim;
  assign busy = r_busy;
  assign done = r_done;
  assign tt   = r_tt;
  assign pass = r_pass;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with default parameters.
module tb_truth_table_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       ack;
  logic       f_in;
  logic [1:0] stim;
  logic       busy;
  logic       done;
  logic [3:0] tt;
  logic       pass;

  int errors = 0;
  int checks = 0;
  int mode   = 0;

  truth_table_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ack   (ack),
    .f_in  (f_in),
    .stim  (stim),
    .busy  (busy),
    .done  (done),
    .tt    (tt),
    .pass  (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural unit under test selected by mode.
  always_comb begin
    case (mode)
      1:       f_in = stim[1] ^ stim[0];
      2:       f_in = stim[1] & stim[0];
      default: f_in = 1'b1;
    endcase
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  // Full sweep from IDLE; start is also pulsed before edge extra_start
  // (0 = never) to show it is ignored while busy.
  task automatic run_sweep(input int m, input logic [3:0] exp_tt,
                           input logic exp_pass, input int extra_start);
    mode  = m;
    start = 1'b1;
    edge_step();                          // edge 1
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) begin
        start = (k == extra_start);
        edge_step();
        start = 1'b0;
      end
      if (k <= 12) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || stim !== 2'((k - 1) / 3)) begin
          errors++;
          $display("FAIL sweep_edge%0d: busy=%b done=%b stim=%b, want busy=1 done=0 stim=%0d",
                   k, busy, done, stim, (k - 1) / 3);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || tt !== exp_tt || pass !== exp_pass || stim !== 2'b11) begin
          errors++;
          $display("FAIL sweep_done: done=%b busy=%b tt=%b pass=%b stim=%b, want 1 0 %b %b 11",
                   done, busy, tt, pass, stim, exp_tt, exp_pass);
        end
      end
    end
  endtask

  task automatic do_ack(input logic [3:0] exp_tt);
    ack = 1'b1;
    edge_step();
    ack = 1'b0;
    checks++;
    if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b0 || tt !== exp_tt) begin
      errors++;
      $display("FAIL after_ack: done=%b pass=%b busy=%b tt=%b, want 0 0 0 %b",
               done, pass, busy, tt, exp_tt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ack = 1'b0; mode = 0;
    #12;
    checks++;
    if (stim !== 2'b00 || tt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: stim=%b tt=%b busy=%b done=%b pass=%b, want all 0",
               stim, tt, busy, done, pass);
    end
    @(negedge clk);
    reset = 1'b0;
    edge_step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_ones_hold_ack();
    run_sweep(0, 4'b1111, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      edge_step();
      checks++;
      if (done !== 1'b1 || tt !== 4'b1111 || pass !== 1'b1) begin
        errors++;
        $display("FAIL done_hold%0d: done=%b tt=%b pass=%b, want 1 1111 1", i, done, tt, pass);
      end
    end
    do_ack(4'b1111);
  endtask

  task automatic test_xor();
    run_sweep(1, 4'b0110, 1'b0, 0);
    do_ack(4'b0110);
  endtask

  task automatic test_and();
    run_sweep(2, 4'b1000, 1'b0, 0);
    do_ack(4'b1000);
  endtask

  task automatic test_reset_mid();
    mode  = 0;
    start = 1'b1;
    edge_step();
    start = 1'b0;
    for (int k = 2; k <= 6; k++) edge_step();
    checks++;
    if (tt !== 4'b0001 || stim !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: tt=%b stim=%b busy=%b, want 0001 01 1", tt, stim, busy);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (stim !== 2'b00 || tt !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: stim=%b tt=%b busy=%b done=%b, want 00 0000 0 0",
               stim, tt, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    edge_step();
    run_sweep(0, 4'b1111, 1'b1, 0);
  endtask

  task automatic test_start_while_busy();
    do_ack(4'b1111);
    run_sweep(1, 4'b0110, 1'b0, 4);
  endtask

  task automatic test_start_ack_together();
    int n;
    start = 1'b1;
    ack   = 1'b1;
    edge_step();
    start = 1'b0;
    ack   = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tt !== 4'b0110) begin
      errors++;
      $display("FAIL start_ack: done=%b busy=%b tt=%b, want 0 0 0110", done, busy, tt);
    end
    for (int i = 0; i < 3; i++) edge_step();
    checks++;
    if (busy !== 1'b0 || tt !== 4'b0110) begin
      errors++;
      $display("FAIL idle_no_sweep: busy=%b tt=%b, want 0 0110", busy, tt);
    end
    mode  = 2;
    start = 1'b1;
    edge_step();
    start = 1'b0;
    checks++;
    if (tt !== 4'b0000 || busy !== 1'b1 || stim !== 2'b00) begin
      errors++;
      $display("FAIL restart_clear: tt=%b busy=%b stim=%b, want 0000 1 00", tt, busy, stim);
    end
    n = 0;
    while (done !== 1'b1 && n < 30) begin
      edge_step();
      n++;
    end
    checks++;
    if (done !== 1'b1 || n != 12 || tt !== 4'b1000) begin
      errors++;
      $display("FAIL restart_done: done=%b edges=%0d tt=%b, want 1 12 1000", done, n, tt);
    end
    do_ack(4'b1000);
  endtask

  initial begin
    test_reset();
    test_ones_hold_ack();
    test_xor();
    test_and();
    test_reset_mid();
    test_start_while_busy();
    test_start_ack_together();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
